exp2_lin: RTL and testbench

//  Pipelined antilog: converts an unsigned 5.16 fixed-point log2 value back to an
//  18-bit linear magnitude, out = round(2^(in/65536)), saturated to 18 bits.

---
 rtl/exp2_lin.sv | 121 ++++++++++++
 tb/tb_exp2_lin.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/exp2_lin.sv
// rtl/exp2_lin.sv - pipelined 5.16 log2 to 18-bit linear antilog
// Four stages: split, mantissa table lookup, interpolation products, scale/round/saturate.
module exp2_lin #(
  parameter int LUT_BITS = 7,
  parameter int OUT_W    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [20:0]      in,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_sat
);

  localparam int N  = 1 << LUT_BITS;
  localparam int AB = 16 - LUT_BITS;
  localparam int PW = 18 + AB + 1;
  localparam int VW = OUT_W + 18;

  // Mantissa table entry round(2^(i/N)*65536), built from a Q64 Taylor series of e^(i*ln2/N).
  function automatic logic [17:0] exp2_entry(input int i);
    logic [127:0] z, term, sum;
    z    = (128'(64'hB17217F7D1CF79AB) * 128'(i)) >> LUT_BITS;
    term = 128'(1) << 64;
    sum  = term;
    for (int k = 1; k <= 24; k++) begin
      term = ((term * z) >> 64) / 128'(k);
      sum  = sum + term;
    end
    return 18'((sum + (128'(1) << 47)) >> 48);
  endfunction

  logic [17:0] w_lut [0:N];
  for (genvar g = 0; g <= N; g++) begin : g_lut
    localparam logic [17:0] C_ENTRY = exp2_entry(g);
    assign w_lut[g] = C_ENTRY;
  end

  logic                r1_v, r1_sat;
  logic [4:0]          r1_e;
  logic [LUT_BITS-1:0] r1_idx;
  logic [AB-1:0]       r1_alpha;

  logic                r2_v, r2_sat;
  logic [4:0]          r2_e;
  logic [17:0]         r2_t0, r2_t1;
  logic [AB-1:0]       r2_alpha;

  logic                r3_v, r3_sat;
  logic [4:0]          r3_e;
  logic [PW-1:0]       r3_p0, r3_p1;

  logic [LUT_BITS:0]   w_idx0, w_idx1;
  logic [AB:0]         w_walpha;
  logic [PW:0]         w_sum;
  logic [17:0]         w_m;
  logic [VW-1:0]       w_shift, w_v;
  logic                w_sat;

  assign w_idx0   = {1'b0, r1_idx};
  assign w_idx1   = w_idx0 + (LUT_BITS+1)'(1);
  assign w_walpha = (AB+1)'(1 << AB) - {1'b0, r2_alpha};

  assign w_sum   = (PW+1)'(r3_p0) + (PW+1)'(r3_p1) + (PW+1)'(1 << (AB-1));
  assign w_m     = 18'(w_sum >> AB);
  assign w_shift = VW'(w_m) << r3_e;
  assign w_v     = (w_shift + VW'(1 << 15)) >> 16;
  assign w_sat   = r3_sat || (w_v > VW'((1 << OUT_W) - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v      <= 1'b0;
      r1_sat    <= 1'b0;
      r1_e      <= '0;
      r1_idx    <= '0;
      r1_alpha  <= '0;
      r2_v      <= 1'b0;
      r2_sat    <= 1'b0;
      r2_e      <= '0;
      r2_t0     <= '0;
      r2_t1     <= '0;
      r2_alpha  <= '0;
      r3_v      <= 1'b0;
      r3_sat    <= 1'b0;
      r3_e      <= '0;
      r3_p0     <= '0;
      r3_p1     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_sat   <= 1'b0;
    end else begin
      r1_v     <= in_valid;
      r1_e     <= in[20:16];
      r1_sat   <= int'(in[20:16]) >= OUT_W;
      r1_idx   <= in[15:AB];
      r1_alpha <= in[AB-1:0];

      r2_v     <= r1_v;
      r2_sat   <= r1_sat;
      r2_e     <= r1_e;
      r2_t0    <= w_lut[w_idx0];
      r2_t1    <= w_lut[w_idx1];
      r2_alpha <= r1_alpha;

      r3_v     <= r2_v;
      r3_sat   <= r2_sat;
      r3_e     <= r2_e;
      r3_p0    <= PW'(r2_t0) * PW'(w_walpha);
      r3_p1    <= PW'(r2_t1) * PW'(r2_alpha);

      out_valid <= r3_v;
      // Result registers hold between valid samples.
      if (r3_v) begin
        out     <= w_sat ? '1 : OUT_W'(w_v);
        out_sat <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_exp2_lin.sv
// tb/tb_exp2_lin.sv - self-checking bench for exp2_lin
// Real-number antilog model plus literal expectations, compared every falling edge.
module tb_exp2_lin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [20:0] in_d = '0;
  logic        out_valid;
  logic [17:0] out;
  logic        out_sat;

  exp2_lin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in_d),
    .out_valid (out_valid),
    .out       (out),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [20:0] x;
    bit          has_lit;
    int          lo;
    int          hi;
    int          lsat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   lit_en = 1'b0;
  int   lit_lo = 0, lit_hi = 0, lit_sat = -1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && in_valid)
      q.push_back('{cyc + 3, in_d, lit_en, lit_lo, lit_hi, lit_sat});
  end

  always @(negedge clk) begin
    exp_t  e;
    bit    exp_v;
    real   r;
    int    ideal, tol, diff;
    bit    ok;
    if (!rst_n) begin
      q.delete();
      chk(out_valid == 1'b0 && out == 18'd0 && out_sat == 1'b0, "reset_outputs",
          int'({out_valid, out_sat, out}), 0);
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk(out_valid == exp_v, "out_valid_timing", int'(out_valid), int'(exp_v));
      if (exp_v) begin
        e = q.pop_front();
        if (out_valid) begin
          r     = 2.0 ** (real'(e.x) / 65536.0);
          ideal = (r >= 262143.5) ? 262143 : $rtoi(r + 0.5);
          tol   = (e.x[8:0] == 9'd0 && e.x[20:16] <= 5'd16) ? 1 : 2;
          diff  = int'(out) - ideal;
          if (diff < 0) diff = -diff;
          if (e.x[20:16] >= 5'd18)
            ok = (out == 18'h3FFFF) && out_sat;
          else
            ok = (diff <= tol) && (!out_sat || out == 18'h3FFFF) && (ideal > 262140 || !out_sat);
          if (!ok)
            $display("in=0x%06h out_sat=%0d", e.x, out_sat);
          chk(ok, "model_value", int'(out), ideal);
          if (e.has_lit) begin
            if (!(int'(out) >= e.lo && int'(out) <= e.hi && (e.lsat < 0 || int'(out_sat) == e.lsat)))
              $display("in=0x%06h range=[%0d,%0d] out_sat=%0d want_sat=%0d", e.x, e.lo, e.hi, out_sat, e.lsat);
            chk(int'(out) >= e.lo && int'(out) <= e.hi && (e.lsat < 0 || int'(out_sat) == e.lsat),
                "literal_value", int'(out), e.lo);
          end
        end
      end
    end
  end

  task automatic send(input logic [20:0] x, input bit has_lit, input int lo, input int hi, input int s);
    in_d     = x;
    in_valid = 1'b1;
    lit_en   = has_lit;
    lit_lo   = lo;
    lit_hi   = hi;
    lit_sat  = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_d     = 'x;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int rt_x [7] = '{1, 2, 3, 1000, 65535, 131071, 262143};

  initial begin
    real lx;
    int  v;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_d     = 21'h100000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(21'h100000, 1'b1, 65536, 65536, 0);
    idle(6);

    send(21'h000000, 1'b1, 1, 1, 0);
    send(21'h100000, 1'b1, 65536, 65536, 0);
    send(21'h110000, 1'b1, 131072, 131072, 0);
    send(21'h108000, 1'b1, 92681, 92683, -1);
    send(21'h120000, 1'b1, 262143, 262143, 1);
    send(21'h1F0000, 1'b1, 262143, 262143, 1);
    send(21'h11FFFF, 1'b1, 262140, 262143, -1);
    send(21'h000001, 1'b1, 1, 1, 0);
    idle(6);

    foreach (rt_x[i]) begin
      lx = $ln(real'(rt_x[i])) / $ln(2.0);
      v  = $rtoi(lx * 65536.0 + 0.5);
      send(21'(v), 1'b1, rt_x[i] - 2, rt_x[i] + 2, -1);
    end
    idle(6);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0)
        send(21'($urandom_range(0, 21'h1FFFFF)), 1'b0, 0, 0, -1);
      else
        send(21'($urandom_range(0, 21'h13FFFF)), 1'b0, 0, 0, -1);
    end
    idle(8);

    send(21'h100000, 1'b0, 0, 0, -1);
    send(21'h108000, 1'b0, 0, 0, -1);
    send(21'h110000, 1'b0, 0, 0, -1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);
    send(21'h0F8000, 1'b1, 46340, 46342, 0);
    idle(8);

    chk(q.size() == 0, "all_emitted", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
